peri_ps2_tx: RTL and testbench

- Host-to-device PS/2 transmitter peripheral. Sends command bytes to the keyboard, e.g. 0xED LED set, 0xFF reset, 0xF4 enable.
- Mirrors the keyboard receive peripheral on the same PS/2 lines. Outputs are open-drain enables for the shared clock and data pads.
- The processor writes a byte through the bus-control write enable and reads a 32-bit status word.
- While a frame is in flight, a receive-inhibit flag is raised so the receive path ignores host-driven traffic.

---
 rtl/peri_ps2_tx.sv | 195 +++++++++++++++++++
 tb/tb_peri_ps2_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/peri_ps2_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// over open-drain clock/data pads and reports progress in a status word.
module peri_ps2_tx #(
    parameter int INHIBIT_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_ps2tx_i,
    input  logic [31:0] data_in_i,
    input  logic        ps2_reloj_i,
    input  logic        ps2_data_i,
    output logic        ps2_clk_oe_o,
    output logic        ps2_data_oe_o,
    output logic        rx_inhibit_o,
    output logic [31:0] out_ps2tx_o
);

    localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQUEST,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } PsState;

    PsState           r_state;
    PsState           w_stateNext;
    logic [CNT_W-1:0] r_cycleCount;
    logic [3:0]       r_edgeCount;
    logic [3:0]       w_edgeNext;
    logic [2:0]       w_bitIdx;
    logic [7:0]       r_byte;
    logic             r_parity;
    logic             r_dataOe;
    logic             r_busy;
    logic             r_done;
    logic             r_ackOk;
    logic             r_nack;
    logic             r_timeout;
    logic             r_clkMeta;
    logic             r_clkSync;
    logic             r_clkPrev;
    logic             r_dataMeta;
    logic             r_dataSync;
    logic             w_clkOe;
    logic             w_fe;
    logic             w_active;
    logic             w_timeoutHit;
    logic             w_accept;
    logic             w_unusedData;

    assign w_unusedData = ^data_in_i[31:8];

    // Bring both asynchronous pads into the clock domain and keep the previous clock sample
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clkMeta  <= 1'b1;
            r_clkSync  <= 1'b1;
            r_clkPrev  <= 1'b1;
            r_dataMeta <= 1'b1;
            r_dataSync <= 1'b1;
        end else begin
            r_clkMeta  <= ps2_reloj_i;
            r_clkSync  <= r_clkMeta;
            r_clkPrev  <= r_clkSync;
            r_dataMeta <= ps2_data_i;
            r_dataSync <= r_dataMeta;
        end
    end

    // Our own clock pull-down must never be mistaken for a device clock edge
    assign w_clkOe      = (r_state == S_INHIBIT);
    assign w_fe         = r_clkPrev & ~r_clkSync & ~w_clkOe;
    assign w_active     = (r_state == S_REQUEST) || (r_state == S_SHIFT) ||
                          (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeoutHit = w_active && (r_cycleCount == TIMEOUT_LAST);
    assign w_accept     = (r_state == S_IDLE) && we_ps2tx_i;
    assign w_edgeNext   = r_edgeCount + 4'd1;
    assign w_bitIdx     = w_edgeNext[2:0] - 3'd1;

    // Next-state selection; a timeout overrides every in-flight state
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:      if (we_ps2tx_i) w_stateNext = S_INHIBIT;
            S_INHIBIT:   if (r_cycleCount == INHIBIT_LAST) w_stateNext = S_REQUEST;
            S_REQUEST:   w_stateNext = S_SHIFT;
            S_SHIFT:     if (w_fe && (w_edgeNext == 4'd10)) w_stateNext = S_ACK;
            S_ACK:       if (w_fe) w_stateNext = S_WAIT_IDLE;
            S_WAIT_IDLE: if (r_clkSync && r_dataSync) w_stateNext = S_DONE;
            S_DONE:      w_stateNext = S_IDLE;
            default:     w_stateNext = S_IDLE;
        endcase
        if (w_timeoutHit) begin
            w_stateNext = S_IDLE;
        end
    end

    // State register, cycle/edge counters, data line drive and sticky status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_cycleCount <= '0;
            r_edgeCount  <= 4'd0;
            r_byte       <= 8'h00;
            r_parity     <= 1'b0;
            r_dataOe     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ackOk      <= 1'b0;
            r_nack       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_stateNext;

            if ((r_state == S_INHIBIT) && (w_stateNext == S_REQUEST)) begin
                r_cycleCount <= '0;
            end else if ((r_state == S_INHIBIT) || w_active) begin
                r_cycleCount <= r_cycleCount + 1'b1;
            end else begin
                r_cycleCount <= '0;
            end

            if (w_accept) begin
                r_byte    <= data_in_i[7:0];
                r_parity  <= ~^data_in_i[7:0];
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
                r_ackOk   <= 1'b0;
                r_nack    <= 1'b0;
                r_timeout <= 1'b0;
            end

            case (r_state)
                S_INHIBIT: begin
                    if (w_stateNext == S_REQUEST) begin
                        r_dataOe    <= 1'b1;
                        r_edgeCount <= 4'd0;
                    end
                end
                S_SHIFT: begin
                    if (w_fe) begin
                        r_edgeCount <= w_edgeNext;
                        case (w_edgeNext)
                            4'd1, 4'd2, 4'd3, 4'd4,
                            4'd5, 4'd6, 4'd7, 4'd8: r_dataOe <= ~r_byte[w_bitIdx];
                            4'd9:                   r_dataOe <= ~r_parity;
                            default:                r_dataOe <= 1'b0;
                        endcase
                    end
                end
                S_ACK: begin
                    if (w_fe) begin
                        r_edgeCount <= w_edgeNext;
                        if (r_dataSync) begin
                            r_nack <= 1'b1;
                        end else begin
                            r_ackOk <= 1'b1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_stateNext == S_DONE) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                end
            endcase

            if (w_timeoutHit) begin
                r_dataOe  <= 1'b0;
                r_timeout <= 1'b1;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
            end
        end
    end

    assign ps2_clk_oe_o  = w_clkOe;
    assign ps2_data_oe_o = r_dataOe;
    assign rx_inhibit_o  = (r_state != S_IDLE);
    assign out_ps2tx_o   = {19'b0, r_timeout, r_nack, r_ackOk, r_done, r_busy, r_byte};

endmodule

// File: tb/tb_peri_ps2_tx.sv
`timescale 1ns/1ps
// Bench for peri_ps2_tx: a keyboard-side model clocks frames out of the
// transmitter while a scoreboard checks the status word at every completion.
module tb_peri_ps2_tx;

   localparam int INHIBIT = 20;
   localparam int TIMEOUT = 2000;
   localparam int HALF    = 20;

   typedef struct {
      logic [7:0]  cmd;
      bit          ackLow;
      int          nEdges;
      logic [9:0]  frame;
      logic [31:0] status;
   } VecT;

   logic        clock = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] dataIn;
   logic        clkOe;
   logic        dataOe;
   logic        rxInhibit;
   logic [31:0] status;
   logic        devClkLow  = 1'b0;
   logic        devDataLow = 1'b0;
   logic        ps2Clk;
   logic        ps2Data;
   logic        prevDone   = 1'b0;

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] expQ[$];
   VecT         vecs[5];

   // Open-drain pads: either side pulling low wins
   assign ps2Clk  = ~(clkOe | devClkLow);
   assign ps2Data = ~(dataOe | devDataLow);

   peri_ps2_tx #(
      .INHIBIT_CYCLES(INHIBIT),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk_i        (clock),
      .rst_i        (reset),
      .we_ps2tx_i   (we),
      .data_in_i    (dataIn),
      .ps2_reloj_i  (ps2Clk),
      .ps2_data_i   (ps2Data),
      .ps2_clk_oe_o (clkOe),
      .ps2_data_oe_o(dataOe),
      .rx_inhibit_o (rxInhibit),
      .out_ps2tx_o  (status)
   );

   // 10 MHz system clock
   always #50 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] cmd, input bit expectDone, input logic [31:0] expStatus);
      @(negedge clock);
      we     = 1'b1;
      dataIn = {24'hA5C3F0, cmd};
      if (expectDone) expQ.push_back(expStatus);
      @(negedge clock);
      we     = 1'b0;
   endtask

   // Keyboard model: measures the inhibit pulse, then clocks nEdges falling edges
   task automatic deviceFrame(input logic [9:0] expFrame, input int nEdges, input bit ackLow);
      int          guard;
      int          cnt;
      logic [9:0]  rx;
      guard = 0;
      while (clkOe == 1'b0 && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      cnt = 0;
      while (clkOe == 1'b1 && cnt < INHIBIT + 50) begin
         cnt++;
         @(negedge clock);
      end
      checkOutput("inhibit length", 32'(cnt), 32'(INHIBIT));
      checkOutput("start bit drive", {30'b0, clkOe, dataOe}, 32'h1);
      if (nEdges == 0) return;
      rx = '0;
      for (int k = 1; k <= nEdges; k++) begin
         repeat (HALF) @(negedge clock);
         if (k == 11) devDataLow = ackLow;
         devClkLow = 1'b1;
         repeat (HALF) @(negedge clock);
         if (k <= 10) rx[k-1] = ps2Data;
         devClkLow = 1'b0;
      end
      if (nEdges == 11) begin
         repeat (HALF) @(negedge clock);
         devDataLow = 1'b0;
         checkOutput("frame bits", 32'(rx), 32'(expFrame));
      end
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (rxInhibit && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (rxInhibit) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL idle wait: still busy after %0d cycles, expected idle", budget);
      end
   endtask

   // Scoreboard monitor: every rising done flag consumes one expected status word
   always @(negedge clock) begin
      if (!reset && status[9] && !prevDone) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected done: status 0x%0h, expected no completion", status);
         end else begin
            checkOutput("status at done", status, expQ.pop_front());
            checkOutput("lines released at done", {30'b0, clkOe, dataOe}, 32'h0);
         end
      end
      prevDone = status[9];
   end

   // Global watchdog so the run can never hang
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence of command bytes
   initial begin
      // cmd, ackLow, nEdges, {stop, parity, byte}, status at completion
      vecs[0] = '{8'hED, 1'b1, 11, 10'b1_1_11101101, 32'h0000_06ED};
      vecs[1] = '{8'h00, 1'b1, 11, 10'b1_1_00000000, 32'h0000_0600};
      vecs[2] = '{8'h01, 1'b1, 11, 10'b1_0_00000001, 32'h0000_0601};
      vecs[3] = '{8'h55, 1'b0, 11, 10'b1_1_01010101, 32'h0000_0A55};
      vecs[4] = '{8'h12, 1'b0, 0,  10'b0,            32'h0000_1212};

      reset  = 1'b1;
      we     = 1'b0;
      dataIn = 32'h0;
      repeat (3) @(negedge clock);
      checkOutput("reset status", status, 32'h0);
      checkOutput("reset lines", {29'b0, rxInhibit, clkOe, dataOe}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].cmd, 1'b1, vecs[i].status);
         checkOutput("status after accept", status, {23'b0, 1'b1, vecs[i].cmd});
         deviceFrame(vecs[i].frame, vecs[i].nEdges, vecs[i].ackLow);
         waitIdle(TIMEOUT + 200);
         checkOutput("idle lines and busy", {29'b0, status[8], clkOe, dataOe}, 32'h0);
      end

      applyStimulus(8'hFF, 1'b1, 32'h0000_06FF);
      fork
         deviceFrame(10'b1_1_11111111, 11, 1'b1);
         begin
            repeat (150) @(negedge clock);
            applyStimulus(8'hF4, 1'b0, 32'h0);
            checkOutput("write while busy ignored", {23'b0, status[8:0]}, 32'h1FF);
         end
      join
      waitIdle(TIMEOUT + 200);

      applyStimulus(8'hA5, 1'b0, 32'h0);
      deviceFrame(10'b0, 5, 1'b0);
      @(negedge clock);
      reset  = 1'b1;
      we     = 1'b1;
      dataIn = 32'h0000_0033;
      @(negedge clock);
      checkOutput("status after mid-frame reset", status, 32'h0);
      checkOutput("lines after mid-frame reset", {29'b0, rxInhibit, clkOe, dataOe}, 32'h0);
      reset = 1'b0;
      we    = 1'b0;

      applyStimulus(8'hF4, 1'b1, 32'h0000_06F4);
      deviceFrame(10'b1_0_11110100, 11, 1'b1);
      waitIdle(TIMEOUT + 200);

      repeat (5) @(negedge clock);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
